// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler sharing one UART transmitter between N_REQ byte
//   producers. Latches the winner's byte, issues a one-cycle TX_START,
//   follows TX_BUSY to detect frame completion, then holds off for an idle
//   gap. A watchdog NACKs a frame that the TX core never accepts.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   REQ[N_REQ]        level request per requester (held until ACK/NACK)
//   REQ_DATA[8*N_REQ] byte for requester i on bits [8i+7:8i]
//   GRANT[N_REQ]      one-hot owner of the transmitter (level)
//   ACK[N_REQ]        one-cycle pulse: owner's frame completed
//   NACK[N_REQ]       one-cycle pulse: owner's frame dropped on timeout
//   TX_DATA[8]        byte presented to the TX core
//   TX_START          one-cycle launch pulse to the TX core
//   TX_BUSY           TX core busy level
//   IDLE              high while waiting for requests
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 1085,
  parameter int ACCEPT_TIMEOUT = 2200
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [8*N_REQ-1:0] REQ_DATA,
  output logic [N_REQ-1:0]   GRANT,
  output logic [N_REQ-1:0]   ACK,
  output logic [N_REQ-1:0]   NACK,
  output logic [7:0]         TX_DATA,
  output logic               TX_START,
  input  logic               TX_BUSY,
  output logic               IDLE
);

  localparam int IDXW = $clog2(N_REQ);
  localparam int WDW  = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;
  localparam int GW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [WDW-1:0]  WD_LAST  = WDW'(ACCEPT_TIMEOUT - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES);
  localparam logic [IDXW-1:0] IDX_MAX  = IDXW'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ACCEPT,
    S_SEND,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  nack_q, nack_d;
  logic [7:0]        data_q, data_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic              win_found;
  logic [IDXW-1:0]   win_idx;
  logic [N_REQ-1:0]  win_oh;
  logic [7:0]        win_data;
  logic [IDXW-1:0]   ptr_after_owner;

  // Round-robin pick as two ascending passes: first requesters at or above
  // ptr, then any requester (only those below ptr can still be unclaimed).
  // Keeps every index a loop constant instead of a rotated variable index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    win_data  = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!win_found && REQ[j] && (IDXW'(j) >= ptr_q)) begin
        win_found = 1'b1;
        win_idx   = IDXW'(j);
        win_oh[j] = 1'b1;
        win_data  = REQ_DATA[8*j +: 8];
      end
    end
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!win_found && REQ[j]) begin
        win_found = 1'b1;
        win_idx   = IDXW'(j);
        win_oh[j] = 1'b1;
        win_data  = REQ_DATA[8*j +: 8];
      end
    end
  end

  assign ptr_after_owner = (owner_q == IDX_MAX) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = '0;
    nack_d  = '0;
    wd_d    = wd_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_oh;
          data_d  = win_data;
          owner_d = win_idx;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (TX_BUSY) begin
          state_d = S_SEND;
        end else if (wd_q == WD_LAST) begin
          nack_d  = grant_q;
          ptr_d   = ptr_after_owner;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_SEND: begin
        if (!TX_BUSY) begin
          ack_d   = grant_q;
          ptr_d   = ptr_after_owner;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // GRANT stays up through the ACK/NACK cycle and drops one edge later.
        grant_d = '0;
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      nack_q  <= '0;
      data_q  <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  assign GRANT    = grant_q;
  assign ACK      = ack_q;
  assign NACK     = nack_q;
  assign TX_DATA  = data_q;
  assign TX_START = (state_q == S_LAUNCH);
  assign IDLE     = (state_q == S_IDLE);

endmodule
